// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if
//   Bundles the three sides of the VRAM arbiter: display fetch port,
//   host write port and the registered single-port RAM command.
//   slave  : arbiter view (drives disp_*, host_ready/ovf, fifo_level, ram_*)
//   master : environment view (drives requests, host writes, ram_rdata)
interface vram_arbiter_if #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // display fetch
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  // host write
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_ovf;
  logic [LVL_W-1:0]  fifo_level;
  // RAM command / read data
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, host_wr, host_addr, host_wdata, ram_rdata,
    output disp_data, disp_valid, host_ready, host_ovf, fifo_level,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, host_wr, host_addr, host_wdata, ram_rdata,
    input  disp_data, disp_valid, host_ready, host_ovf, fifo_level,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port VRAM between a display fetch stream and a
//   FIFO-buffered host write stream. Display always wins; queued writes
//   drain one per cycle whenever no fetch is requested.
//   Ports:
//     clock : single clock, all state on rising edge
//     reset : asynchronous, active-low
//     bus   : vram_arbiter_if.slave (display, host and RAM command signals)
//   Fetch latency: disp_req in cycle 0 -> RAM read in cycle 1 ->
//   ram_rdata in cycle 2 -> disp_data/disp_valid in cycle 3.
module vram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STAGES = 1;

  // Encoding chosen so ram_en/ram_we are the state flops themselves.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RD   = 2'b10;
  localparam logic [1:0] WR   = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic [1:0]        state, nxt;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              disp_valid_q;
  logic [STAGES:0]   vld_pipe;

  wr_req_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              host_ovf_q;
  logic              host_ready;
  logic              push, pop;
  wr_req_t           head;

  assign host_ready = (count < LVL_W'(FIFO_DEPTH));
  assign push       = bus.host_wr && host_ready;
  assign head       = mem[rd_ptr];

  // Fixed priority; emptiness uses the pre-edge count so a write pushed
  // on this edge cannot be popped until the next one.
  always_comb begin
    nxt = IDLE;
    if (bus.disp_req)    nxt = RD;
    else if (count != 0) nxt = WR;
  end

  assign pop = (nxt == WR);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- host write FIFO ----------------
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{addr: bus.host_addr, data: bus.host_wdata};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      host_ovf_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.host_wr && !host_ready) host_ovf_q <= 1'b1;
    end
  end

  // ---------------- RAM command ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state <= nxt;
      case (nxt)
        RD: ram_addr_q <= bus.disp_addr;
        WR: begin
          ram_addr_q  <= head.addr;
          ram_wdata_q <= head.data;
        end
        default: ;  // IDLE holds address/data
      endcase
    end
  end

  // ---------------- fetch return pipe ----------------
  // vld_pipe[0]: read command on RAM, vld_pipe[1]: ram_rdata valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe     <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:0], bus.disp_req};
      disp_valid_q <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) disp_data_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_en     = state[1];
  assign bus.ram_we     = state[0];
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.host_ready = host_ready;
  assign bus.host_ovf   = host_ovf_q;
  assign bus.fifo_level = count;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed bench for vram_arbiter with a behavioural single-port RAM
//   (one-cycle read latency) attached to the RAM command port.
module tb_vram_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] vram [1024];

  always @(posedge clock) begin
    if (bus.ram_en) begin
      if (bus.ram_we) vram[bus.ram_addr[9:0]] <= bus.ram_wdata;
      else            bus.ram_rdata <= vram[bus.ram_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int n_we, n_vld;

  initial begin
    bus.disp_req   = 1'b0;
    bus.disp_addr  = '0;
    bus.host_wr    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
    vram[10'h010] = 8'hA5;
    vram[10'h020] = 8'h11;
    vram[10'h021] = 8'h22;
    vram[10'h022] = 8'h33;

    // ---- reset state ----
    #1;
    chk("rst_ram_en",     32'(bus.ram_en),     32'h0);
    chk("rst_ram_we",     32'(bus.ram_we),     32'h0);
    chk("rst_ram_addr",   32'(bus.ram_addr),   32'h0);
    chk("rst_ram_wdata",  32'(bus.ram_wdata),  32'h0);
    chk("rst_disp_data",  32'(bus.disp_data),  32'h0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 32'h0);
    chk("rst_level",      32'(bus.fifo_level), 32'h0);
    chk("rst_ready",      32'(bus.host_ready), 32'h1);
    chk("rst_ovf",        32'(bus.host_ovf),   32'h0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // ---- single fetch ----
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00010;
    tick();
    bus.disp_req = 1'b0;
    chk("sf_ram_en",   32'(bus.ram_en),   32'h1);
    chk("sf_ram_we",   32'(bus.ram_we),   32'h0);
    chk("sf_ram_addr", 32'(bus.ram_addr), 32'h10);
    tick();
    chk("sf_c2_valid", 32'(bus.disp_valid), 32'h0);
    tick();
    chk("sf_c3_valid", 32'(bus.disp_valid), 32'h1);
    chk("sf_c3_data",  32'(bus.disp_data),  32'hA5);
    tick();
    chk("sf_c4_valid", 32'(bus.disp_valid), 32'h0);
    chk("sf_c4_hold",  32'(bus.disp_data),  32'hA5);

    // ---- back-to-back fetches ----
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00020;
    tick(); bus.disp_addr = 19'h00021;
    tick(); bus.disp_addr = 19'h00022;
    tick(); bus.disp_req = 1'b0;
    chk("b2b_v0", 32'(bus.disp_valid), 32'h1);
    chk("b2b_d0", 32'(bus.disp_data),  32'h11);
    tick();
    chk("b2b_v1", 32'(bus.disp_valid), 32'h1);
    chk("b2b_d1", 32'(bus.disp_data),  32'h22);
    tick();
    chk("b2b_v2", 32'(bus.disp_valid), 32'h1);
    chk("b2b_d2", 32'(bus.disp_data),  32'h33);
    tick();
    chk("b2b_end", 32'(bus.disp_valid), 32'h0);

    // ---- contention: 2 writes queued behind 800 fetch cycles ----
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00020;
    bus.host_wr = 1'b1; bus.host_addr = 19'h00100; bus.host_wdata = 8'h5A;
    tick();
    bus.host_addr = 19'h00101; bus.host_wdata = 8'h6B;
    tick();
    bus.host_wr = 1'b0;
    chk("ct_level2", 32'(bus.fifo_level), 32'h2);
    n_we = 0;
    for (int i = 0; i < 798; i++) begin
      tick();
      if (bus.ram_we) n_we++;
    end
    chk("ct_no_wr", 32'(n_we), 32'h0);
    chk("ct_level_held", 32'(bus.fifo_level), 32'h2);
    bus.disp_req = 1'b0;
    tick();
    chk("ct_wr0_we",   32'(bus.ram_we),    32'h1);
    chk("ct_wr0_addr", 32'(bus.ram_addr),  32'h100);
    chk("ct_wr0_data", 32'(bus.ram_wdata), 32'h5A);
    tick();
    chk("ct_wr1_we",   32'(bus.ram_we),    32'h1);
    chk("ct_wr1_addr", 32'(bus.ram_addr),  32'h101);
    chk("ct_wr1_data", 32'(bus.ram_wdata), 32'h6B);
    tick();
    chk("ct_idle_en",  32'(bus.ram_en),     32'h0);
    chk("ct_idle_addr", 32'(bus.ram_addr),  32'h101);
    chk("ct_level0",   32'(bus.fifo_level), 32'h0);

    // read back a drained write
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00100;
    tick(); bus.disp_req = 1'b0;
    tick(); tick();
    chk("rb_valid", 32'(bus.disp_valid), 32'h1);
    chk("rb_data",  32'(bus.disp_data),  32'h5A);

    // ---- full FIFO: 5 writes while display holds the RAM ----
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00030;
    for (int i = 0; i < 5; i++) begin
      bus.host_wr = 1'b1; bus.host_addr = 19'(32'h200 + i); bus.host_wdata = 8'(8'h80 + i);
      tick();
      if (i == 3) begin
        chk("ff_level4", 32'(bus.fifo_level), 32'h4);
        chk("ff_ready0", 32'(bus.host_ready), 32'h0);
        chk("ff_ovf0",   32'(bus.host_ovf),   32'h0);
      end
    end
    bus.host_wr = 1'b0;
    chk("ff_level_cap", 32'(bus.fifo_level), 32'h4);
    chk("ff_ovf1",      32'(bus.host_ovf),   32'h1);
    bus.disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ff_drain_we",   32'(bus.ram_we),    32'h1);
      chk("ff_drain_addr", 32'(bus.ram_addr),  32'h200 + 32'(i));
      chk("ff_drain_data", 32'(bus.ram_wdata), 32'h80 + 32'(i));
    end
    tick();
    chk("ff_drained_en", 32'(bus.ram_en),     32'h0);
    chk("ff_drained_lv", 32'(bus.fifo_level), 32'h0);
    chk("ff_ovf_sticky", 32'(bus.host_ovf),   32'h1);

    // ---- push and pop on the same edge ----
    bus.disp_req = 1'b1;
    bus.host_wr = 1'b1; bus.host_addr = 19'h00300; bus.host_wdata = 8'hC0;
    tick();
    chk("pp_level1", 32'(bus.fifo_level), 32'h1);
    bus.disp_req = 1'b0;
    bus.host_addr = 19'h00301; bus.host_wdata = 8'hC1;
    tick();
    bus.host_wr = 1'b0;
    chk("pp_we",     32'(bus.ram_we),     32'h1);
    chk("pp_addr",   32'(bus.ram_addr),   32'h300);
    chk("pp_level",  32'(bus.fifo_level), 32'h1);
    tick();
    chk("pp_addr2",  32'(bus.ram_addr),   32'h301);
    chk("pp_data2",  32'(bus.ram_wdata),  32'hC1);
    chk("pp_level0", 32'(bus.fifo_level), 32'h0);

    // ---- reset mid-fetch ----
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00010;
    tick();
    bus.disp_req = 1'b0;
    chk("rm_pre_en", 32'(bus.ram_en), 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("rm_en",    32'(bus.ram_en),     32'h0);
    chk("rm_valid", 32'(bus.disp_valid), 32'h0);
    chk("rm_data",  32'(bus.disp_data),  32'h0);
    chk("rm_ovf",   32'(bus.host_ovf),   32'h0);
    chk("rm_addr",  32'(bus.ram_addr),   32'h0);
    tick();
    reset = 1'b1;
    n_vld = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.disp_valid) n_vld++;
    end
    chk("rm_no_valid", 32'(n_vld), 32'h0);
    bus.disp_req = 1'b1;
    tick(); bus.disp_req = 1'b0;
    tick(); tick();
    chk("rm_new_valid", 32'(bus.disp_valid), 32'h1);
    chk("rm_new_data",  32'(bus.disp_data),  32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, VRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, VRAM data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, host write FIFO entries (power of two).
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port disp_req  in  1  display pixel fetch request, sampled every cycle.
REQ-007 SHALL have port disp_addr  in  ADDR_W  display fetch address.
REQ-008 SHALL have port disp_data  out  DATA_W  fetched pixel, registered.
REQ-009 SHALL have port disp_valid  out  1  disp_data valid, one-cycle pulse per fetch.
REQ-010 SHALL have port host_wr  in  1  host write strobe.
REQ-011 SHALL have port host_addr  in  ADDR_W  host write address.
REQ-012 SHALL have port host_wdata  in  DATA_W  host write data.
REQ-013 SHALL have port host_ready  out  1  FIFO not full; write accepted only when high.
REQ-014 SHALL have port host_ovf  out  1  sticky flag: host_wr seen while host_ready low.
REQ-015 SHALL have port fifo_level  out  log2(FIFO_DEPTH)+1  queued write count.
REQ-016 SHALL have ports ram_en, ram_we (out 1), ram_addr (out ADDR_W), ram_wdata (out DATA_W): registered single-port RAM command.
REQ-017 SHALL have port ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read command.

Function
REQ-018 SHALL implement states IDLE, RD, WR for the registered RAM command; next state chosen each cycle by fixed priority: disp_req -> RD; else FIFO non-empty -> WR; else IDLE.
REQ-019 SHALL give display absolute priority; a queued write never delays a fetch.
REQ-020 SHALL, in RD, drive ram_en=1, ram_we=0, ram_addr=disp_addr sampled the previous edge.
REQ-021 SHALL, in WR, drive ram_en=1, ram_we=1, ram_addr/ram_wdata = FIFO head, and pop the head on the same edge the WR state is entered.
REQ-022 SHALL, in IDLE, drive ram_en=0, ram_we=0; ram_addr/ram_wdata hold last value.
REQ-023 SHALL produce fetch latency of exactly 3 cycles: disp_req high in cycle 0 -> ram RD in cycle 1 -> disp_data/disp_valid in cycle 3 = ram_rdata of cycle 2.
REQ-024 SHALL sustain one fetch per cycle for back-to-back disp_req, preserving order.
REQ-025 SHALL hold disp_data between pulses; disp_valid low when no fetch completes.
REQ-026 SHALL accept a write when host_wr && host_ready at the edge; host_ready = (fifo_level < FIFO_DEPTH).
REQ-027 SHALL not bypass: an entry pushed at edge k is poppable no earlier than edge k+1.
REQ-028 SHALL keep fifo_level unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-029 SHALL ignore host_wr while full and set host_ovf, held until reset.
REQ-030 SHALL drain writes FIFO order, one per non-fetch cycle.

Reset
REQ-031 SHALL on reset=0 immediately force: state IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_data=0, disp_valid=0, FIFO empty, fifo_level=0, host_ready=1, host_ovf=0.
REQ-032 SHALL discard in-flight fetches on reset; no disp_valid pulse for requests issued before reset release.
REQ-033 SHALL sample first disp_req/host_wr on the first rising edge after reset returns to 1.

Verification
REQ-034 Single fetch: disp_req=1 one cycle, addr 0x00010, RAM holds 0xA5 -> ram_en=1/ram_we=0/addr 0x00010 next cycle; disp_valid=1, disp_data=0xA5 three cycles after request.
REQ-035 Contention: 2 writes queued, disp_req held 800 cycles -> no WR during the 800 RD cycles; both writes issued in the 2 cycles after disp_req falls, in order.
REQ-036 Full FIFO: 5 host_wr with disp_req=1 -> host_ready low after 4th, 5th dropped, fifo_level=4, host_ovf=1.
REQ-037 Push+pop same cycle: fifo_level=1, disp_req=0, host_wr=1 -> fifo_level stays 1, pop and push both occur.
REQ-038 Reset mid-fetch: reset=0 one cycle after disp_req -> ram_en=0 and disp_valid=0 immediately; no disp_valid after release until new request.
